// File: rtl/sram_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the SRAM pads and the arbiter.
// master = requester and pad side, slave = arbiter.
interface sram_arbiter_if #(
   parameter int unsigned SRAM_AW = 20
);
   logic               if_req;
   logic [31:0]        if_addr;
   logic [31:0]        if_rdata;
   logic               if_ready;
   logic               mem_req;
   logic               mem_we;
   logic [3:0]         mem_be;
   logic [31:0]        mem_addr;
   logic [31:0]        mem_wdata;
   logic [31:0]        mem_rdata;
   logic               mem_ready;
   logic [SRAM_AW-1:0] sram_addr;
   logic [31:0]        sram_wdata;
   logic               sram_wdata_oe;
   logic [31:0]        sram_rdata;
   logic               sram_ce_n;
   logic               sram_oe_n;
   logic               sram_we_n;
   logic [3:0]         sram_be_n;
   logic               stall_o;

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_be,
      output mem_addr, mem_wdata, sram_rdata,
      input  if_rdata, if_ready, mem_rdata, mem_ready,
      input  sram_addr, sram_wdata, sram_wdata_oe,
      input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, stall_o
   );

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_be,
      input  mem_addr, mem_wdata, sram_rdata,
      output if_rdata, if_ready, mem_rdata, mem_ready,
      output sram_addr, sram_wdata, sram_wdata_oe,
      output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, stall_o
   );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and the data port.
// Fixed-length accesses, registered pad strobes, one-cycle ready pulses.
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 20
) (
   input  logic          clk,
   input  logic          rst,
   sram_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam logic [3:0] WC       = 4'(WAIT_CYCLES);

   logic [1:0]         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               last_data_q, last_data_d;
   logic               gnt_data_q, gnt_data_d;
   logic               we_q, we_d;
   logic [3:0]         be_q, be_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic [3:0]         be_n_q, be_n_d;
   logic               wdata_oe_q, wdata_oe_d;
   logic [31:0]        if_rdata_q, if_rdata_d;
   logic [31:0]        mem_rdata_q, mem_rdata_d;
   logic               if_ready_q, if_ready_d;
   logic               mem_ready_q, mem_ready_d;
   logic               pick_data;
   logic               in_acc;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_data_d = last_data_q;
      gnt_data_d  = gnt_data_q;
      we_d        = we_q;
      be_d        = be_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      pick_data   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.mem_req || bus.if_req) begin
               // Data wins unless it also won last time and fetch waits.
               pick_data   = bus.mem_req & ~(bus.if_req & last_data_q);
               gnt_data_d  = pick_data;
               last_data_d = pick_data;
               we_d        = pick_data & bus.mem_we;
               be_d        = pick_data ? bus.mem_be : 4'h0;
               addr_d      = pick_data ? bus.mem_addr[SRAM_AW+1:2]
                                       : bus.if_addr[SRAM_AW+1:2];
               if (pick_data && bus.mem_we) wdata_d = bus.mem_wdata;
               state_d     = S_ACCESS;
               cnt_d       = 4'd1;
            end
         end
         S_ACCESS: begin
            if (cnt_q == WC) begin
               state_d = S_DONE;
               if (!we_q && gnt_data_q)  mem_rdata_d = bus.sram_rdata;
               if (!we_q && !gnt_data_q) if_rdata_d  = bus.sram_rdata;
               mem_ready_d = gnt_data_q;
               if_ready_d  = ~gnt_data_q;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      // Pad strobes are registered from the next-state view of the access.
      in_acc     = (state_d == S_ACCESS);
      ce_n_d     = ~in_acc;
      oe_n_d     = ~(in_acc & ~we_d);
      we_n_d     = ~(in_acc & we_d & (cnt_d >= 4'd2));
      be_n_d     = in_acc ? (we_d ? ~be_d : 4'h0) : 4'hF;
      wdata_oe_d = in_acc & we_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         last_data_q <= 1'b0;
         gnt_data_q  <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= 4'h0;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         be_n_q      <= 4'hF;
         wdata_oe_q  <= 1'b0;
         if_rdata_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_data_q <= last_data_d;
         gnt_data_q  <= gnt_data_d;
         we_q        <= we_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         be_n_q      <= be_n_d;
         wdata_oe_q  <= wdata_oe_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
      end
   end

   assign bus.sram_addr     = addr_q;
   assign bus.sram_wdata    = wdata_q;
   assign bus.sram_wdata_oe = wdata_oe_q;
   assign bus.sram_ce_n     = ce_n_q;
   assign bus.sram_oe_n     = oe_n_q;
   assign bus.sram_we_n     = we_n_q;
   assign bus.sram_be_n     = be_n_q;
   assign bus.if_rdata      = if_rdata_q;
   assign bus.mem_rdata     = mem_rdata_q;
   assign bus.if_ready      = if_ready_q;
   assign bus.mem_ready     = mem_ready_q;
   assign bus.stall_o       = (bus.mem_req & ~mem_ready_q)
                            | (bus.if_req & ~if_ready_q);
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with WAIT_CYCLES=2.
// SRAM read data is a fixed word or {12'hC0D, sram_addr}.
module tb_sram_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_arbiter_if #(.SRAM_AW(20)) bus ();

   sram_arbiter #(
      .WAIT_CYCLES(2),
      .SRAM_AW    (20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   logic        use_fixed;
   logic [31:0] fixed_rd;

   always_comb begin
      bus.sram_rdata = use_fixed ? fixed_rd : {12'hC0D, bus.sram_addr};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] strobes();
      return {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
              bus.sram_be_n, bus.sram_wdata_oe};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (strobes() !== 8'hFE) begin
         errors++;
         $display("FAIL reset_strobes got=%h exp=fe", strobes());
      end
      checks++;
      if (bus.sram_addr !== 20'h0 || bus.sram_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr_wdata got=%h/%h exp=0/0",
                  bus.sram_addr, bus.sram_wdata);
      end
      checks++;
      if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata got=%h/%h exp=0/0",
                  bus.if_rdata, bus.mem_rdata);
      end
      checks++;
      if ({bus.if_ready, bus.mem_ready, bus.stall_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=000",
                  {bus.if_ready, bus.mem_ready, bus.stall_o});
      end
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      int rdy_at, rdy_n, oe_low, bad_addr;
      rdy_at = 0; rdy_n = 0; oe_low = 0; bad_addr = 0;
      use_fixed   = 1'b1;
      fixed_rd    = 32'h2402_0001;
      bus.if_addr = 32'h0000_0010;
      bus.if_req  = 1'b1;
      #1;
      checks++;
      if (bus.stall_o !== 1'b1) begin
         errors++;
         $display("FAIL fetch_stall got=%b exp=1", bus.stall_o);
      end
      for (int c = 1; c <= 8; c++) begin
         step();
         if (!bus.sram_oe_n) oe_low++;
         if (!bus.sram_ce_n && bus.sram_addr !== 20'h4) bad_addr++;
         if (bus.if_ready) begin
            rdy_n++;
            if (rdy_at == 0) begin
               rdy_at = c;
               checks++;
               if (bus.if_rdata !== 32'h2402_0001) begin
                  errors++;
                  $display("FAIL fetch_rdata got=%h exp=24020001",
                           bus.if_rdata);
               end
            end
            bus.if_req = 1'b0;
         end
      end
      checks++;
      if (rdy_at != 3 || rdy_n != 1) begin
         errors++;
         $display("FAIL fetch_ready at=%0d n=%0d exp at=3 n=1",
                  rdy_at, rdy_n);
      end
      checks++;
      if (oe_low != 2 || bad_addr != 0) begin
         errors++;
         $display("FAIL fetch_oe oe_low=%0d bad_addr=%0d exp 2/0",
                  oe_low, bad_addr);
      end
      checks++;
      if (bus.if_rdata !== 32'h2402_0001) begin
         errors++;
         $display("FAIL fetch_hold got=%h exp=24020001", bus.if_rdata);
      end
      use_fixed = 1'b0;
   endtask

   task automatic test_sb();
      int rdy_at, rdy_n, we_low, woe, bad;
      rdy_at = 0; rdy_n = 0; we_low = 0; woe = 0; bad = 0;
      bus.mem_we    = 1'b1;
      bus.mem_be    = 4'b0100;
      bus.mem_addr  = 32'h0000_0106;
      bus.mem_wdata = 32'h00AB_0000;
      bus.mem_req   = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (!bus.sram_we_n) we_low++;
         if (bus.sram_wdata_oe) woe++;
         if (bus.sram_wdata_oe && bus.sram_ce_n) bad++;
         if (!bus.sram_ce_n) begin
            if (bus.sram_be_n !== 4'b1011) bad++;
            if (bus.sram_oe_n !== 1'b1) bad++;
            if (bus.sram_addr !== 20'h41) bad++;
            if (bus.sram_wdata !== 32'h00AB_0000) bad++;
         end
         if (bus.mem_ready) begin
            rdy_n++;
            if (rdy_at == 0) rdy_at = c;
            bus.mem_req = 1'b0;
            bus.mem_we  = 1'b0;
         end
      end
      checks++;
      if (rdy_at != 3 || rdy_n != 1) begin
         errors++;
         $display("FAIL sb_ready at=%0d n=%0d exp at=3 n=1", rdy_at, rdy_n);
      end
      checks++;
      if (we_low != 1) begin
         errors++;
         $display("FAIL sb_we_low got=%0d exp=1", we_low);
      end
      checks++;
      if (woe != 2 || bad != 0) begin
         errors++;
         $display("FAIL sb_pins woe=%0d bad=%0d exp 2/0", woe, bad);
      end
      checks++;
      if (bus.mem_rdata !== 32'h0) begin
         errors++;
         $display("FAIL sb_rdata got=%h exp=0", bus.mem_rdata);
      end
   endtask

   task automatic test_simul();
      int m_at, f_at, stall_bad, addr_bad;
      m_at = 0; f_at = 0; stall_bad = 0; addr_bad = 0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.mem_we   = 1'b0;
      bus.mem_be   = 4'hF;
      bus.mem_addr = 32'h0000_0200;
      bus.if_addr  = 32'h0000_0040;
      bus.mem_req  = 1'b1;
      bus.if_req   = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (f_at == 0 && !bus.if_ready && bus.stall_o !== 1'b1) stall_bad++;
         if (!bus.sram_ce_n && c <= 3 && bus.sram_addr !== 20'h80) addr_bad++;
         if (!bus.sram_ce_n && c >= 5 && bus.sram_addr !== 20'h10) addr_bad++;
         if (bus.mem_ready) begin
            m_at = c;
            checks++;
            if (bus.mem_rdata !== 32'hC0D0_0080) begin
               errors++;
               $display("FAIL simul_mem_rdata got=%h exp=c0d00080",
                        bus.mem_rdata);
            end
            bus.mem_req = 1'b0;
         end
         if (bus.if_ready) begin
            f_at = c;
            checks++;
            if (bus.if_rdata !== 32'hC0D0_0010) begin
               errors++;
               $display("FAIL simul_if_rdata got=%h exp=c0d00010",
                        bus.if_rdata);
            end
            bus.if_req = 1'b0;
         end
      end
      checks++;
      if (m_at != 3 || f_at != 7) begin
         errors++;
         $display("FAIL simul_order mem_at=%0d if_at=%0d exp 3/7", m_at, f_at);
      end
      checks++;
      if (stall_bad != 0 || addr_bad != 0) begin
         errors++;
         $display("FAIL simul_stall stall_bad=%0d addr_bad=%0d exp 0/0",
                  stall_bad, addr_bad);
      end
   endtask

   task automatic test_back_to_back();
      int n, dn, last_at;
      logic [2:0] ord;
      n = 0; dn = 0; last_at = 0; ord = 3'b000;
      bus.mem_addr = 32'hFFC0_0303;
      bus.if_addr  = 32'h0000_0080;
      bus.mem_req  = 1'b1;
      bus.if_req   = 1'b1;
      for (int c = 1; c <= 20 && n < 3; c++) begin
         step();
         if (bus.mem_ready) begin
            ord = {ord[1:0], 1'b1};
            n++;
            last_at = c;
            checks++;
            if (dn == 0 && bus.mem_rdata !== 32'hC0D0_00C0) begin
               errors++;
               $display("FAIL b2b_d0 got=%h exp=c0d000c0", bus.mem_rdata);
            end
            if (dn == 1 && bus.mem_rdata !== 32'hC0D0_00C1) begin
               errors++;
               $display("FAIL b2b_d1 got=%h exp=c0d000c1", bus.mem_rdata);
            end
            dn++;
            if (dn == 1) bus.mem_addr = 32'h0000_0304;
            else bus.mem_req = 1'b0;
         end
         if (bus.if_ready) begin
            ord = {ord[1:0], 1'b0};
            n++;
            last_at = c;
            checks++;
            if (bus.if_rdata !== 32'hC0D0_0020) begin
               errors++;
               $display("FAIL b2b_f got=%h exp=c0d00020", bus.if_rdata);
            end
            bus.if_req = 1'b0;
         end
      end
      bus.mem_req = 1'b0;
      bus.if_req  = 1'b0;
      checks++;
      if (n != 3 || ord !== 3'b101 || last_at != 11) begin
         errors++;
         $display("FAIL b2b_grants n=%0d order=%b last=%0d exp 3/101/11",
                  n, ord, last_at);
      end
      step();
      step();
   endtask

   task automatic test_reset_mid();
      int rdy_at, rdy_n;
      rdy_at = 0; rdy_n = 0;
      bus.if_addr = 32'h0000_0044;
      bus.if_req  = 1'b1;
      step();
      checks++;
      if (bus.sram_ce_n !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_started ce_n=%b exp=0", bus.sram_ce_n);
      end
      rst = 1'b1;
      step();
      checks++;
      if (strobes() !== 8'hFE || bus.if_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_abort strobes=%h rdy=%b exp fe/0",
                  strobes(), bus.if_ready);
      end
      checks++;
      if (bus.if_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_rdata got=%h exp=0", bus.if_rdata);
      end
      rst = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (bus.if_ready) begin
            rdy_n++;
            if (rdy_at == 0) rdy_at = c;
            bus.if_req = 1'b0;
         end
      end
      checks++;
      if (rdy_at != 3 || rdy_n != 1 || bus.if_rdata !== 32'hC0D0_0011) begin
         errors++;
         $display("FAIL rstmid_reissue at=%0d n=%0d rdata=%h exp 3/1/c0d00011",
                  rdy_at, rdy_n, bus.if_rdata);
      end
   endtask

   task automatic test_drop();
      int rdy_at, rdy_n, ce_low;
      rdy_at = 0; rdy_n = 0; ce_low = 0;
      bus.mem_we   = 1'b0;
      bus.mem_addr = 32'h0000_0400;
      bus.mem_req  = 1'b1;
      step();
      if (!bus.sram_ce_n) ce_low++;
      bus.mem_req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (!bus.sram_ce_n) ce_low++;
         if (bus.mem_ready) begin
            rdy_n++;
            if (rdy_at == 0) rdy_at = c;
         end
      end
      checks++;
      if (rdy_at != 2 || rdy_n != 1) begin
         errors++;
         $display("FAIL drop_ready at=%0d n=%0d exp 2/1", rdy_at, rdy_n);
      end
      checks++;
      if (ce_low != 2) begin
         errors++;
         $display("FAIL drop_ce_low got=%0d exp=2", ce_low);
      end
      checks++;
      if (bus.mem_rdata !== 32'hC0D0_0100) begin
         errors++;
         $display("FAIL drop_rdata got=%h exp=c0d00100", bus.mem_rdata);
      end
   endtask

   initial begin
      rst           = 1'b1;
      use_fixed     = 1'b0;
      fixed_rd      = 32'h0;
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'h0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_be    = 4'h0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      test_reset();
      test_fetch();
      test_sb();
      test_simul();
      test_back_to_back();
      test_reset_mid();
      test_drop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
